binary_to_bcd_seq: RTL and testbench

- Multi-cycle, handshaked binary-to-BCD converter using the double-dabble algorithm, processing one bit per clock.
- Sits between arithmetic result registers and display/formatting logic, e.g. in front of the seven-segment driver.
- Parametrised in input width and digit count.
- Signed (2's complement) or unsigned interpretation is selected per transaction.
- Overflow handling is selectable: saturate or truncate.

---
 rtl/binary_to_bcd_seq_if.sv | 27 ++
 rtl/binary_to_bcd_seq.sv | 128 ++++++++++++
 tb/tb_binary_to_bcd_seq.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/binary_to_bcd_seq_if.sv
// Handshake bundle for the sequential binary-to-BCD converter.
// The slave modport is the converter; the master modport is the side
// that supplies binary values and consumes BCD results.
interface binary_to_bcd_seq_if #(
  parameter int BIN_WIDTH  = 20,
  parameter int BCD_DIGITS = 6
);
  logic                    in_valid;
  logic                    in_ready;
  logic [BIN_WIDTH-1:0]    in_binary;
  logic                    in_signed;
  logic                    out_valid;
  logic                    out_ready;
  logic [4*BCD_DIGITS-1:0] out_bcd;
  logic                    out_negative;
  logic                    out_overflow;

  modport slave (
    input  in_valid, in_binary, in_signed, out_ready,
    output in_ready, out_valid, out_bcd, out_negative, out_overflow
  );

  modport master (
    output in_valid, in_binary, in_signed, out_ready,
    input  in_ready, out_valid, out_bcd, out_negative, out_overflow
  );
endinterface

// File: rtl/binary_to_bcd_seq.sv
// Multi-cycle double-dabble binary-to-BCD converter, one input bit per clock.
// Accepts signed or unsigned values, reports sign and overflow, and either
// saturates to all nines or keeps the low digits when the value does not fit.
module binary_to_bcd_seq #(
  parameter int BIN_WIDTH  = 20,
  parameter int BCD_DIGITS = 6,
  parameter bit SATURATE   = 1'b1
) (
  input  logic                clk,
  input  logic                reset_n,
  binary_to_bcd_seq_if.slave  bus
);

  localparam int BCD_W = 4 * BCD_DIGITS;
  localparam int SR_W  = BCD_W + BIN_WIDTH;
  localparam int CNT_W = $clog2(BIN_WIDTH + 1);
  // Wide enough for both the magnitude and 10^BCD_DIGITS - 1.
  localparam int CMP_W = (BIN_WIDTH > BCD_W + 1) ? BIN_WIDTH : BCD_W + 1;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  localparam logic [CMP_W-1:0] MAX_VAL = CMP_W'(pow10(BCD_DIGITS) - 64'd1);

  typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SR_W-1:0]     sr_q, sr_d;
  logic                neg_q, neg_d;
  logic                ovf_q, ovf_d;
  logic [BCD_W-1:0]    bcd_q, bcd_d;
  logic                out_neg_q, out_neg_d;
  logic                out_ovf_q, out_ovf_d;

  logic                in_neg;
  logic [BIN_WIDTH-1:0] in_abs;
  logic [BCD_W-1:0]    bcd_adj;
  logic [SR_W-1:0]     sr_shift;

  // Sign and magnitude of the offered input; the most-negative value maps
  // to 2^(BIN_WIDTH-1), which still fits as an unsigned BIN_WIDTH number.
  assign in_neg = bus.in_signed & bus.in_binary[BIN_WIDTH-1];
  assign in_abs = in_neg ? (~bus.in_binary + BIN_WIDTH'(1)) : bus.in_binary;

  // Add-3 correction on every nibble of the pre-shift BCD field.
  for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_adj
    assign bcd_adj[gi*4 +: 4] = (sr_q[BIN_WIDTH + gi*4 +: 4] >= 4'd5)
                              ? sr_q[BIN_WIDTH + gi*4 +: 4] + 4'd3
                              : sr_q[BIN_WIDTH + gi*4 +: 4];
  end

  // Carries out of the top digit fall off here, which yields the
  // low-digit result when truncating.
  assign sr_shift = {bcd_adj, sr_q[BIN_WIDTH-1:0]} << 1;

  // Next-state and datapath update for IDLE / CONVERT / DONE.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sr_d      = sr_q;
    neg_d     = neg_q;
    ovf_d     = ovf_q;
    bcd_d     = bcd_q;
    out_neg_d = out_neg_q;
    out_ovf_d = out_ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          neg_d   = in_neg;
          ovf_d   = CMP_W'(in_abs) > MAX_VAL;
          sr_d    = {{BCD_W{1'b0}}, in_abs};
          cnt_d   = '0;
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        sr_d  = sr_shift;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(BIN_WIDTH - 1)) begin
          state_d   = DONE;
          bcd_d     = (SATURATE && ovf_q) ? {BCD_DIGITS{4'h9}}
                                          : sr_shift[SR_W-1 -: BCD_W];
          out_neg_d = neg_q;
          out_ovf_d = ovf_q;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sr_q      <= '0;
      neg_q     <= 1'b0;
      ovf_q     <= 1'b0;
      bcd_q     <= '0;
      out_neg_q <= 1'b0;
      out_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sr_q      <= sr_d;
      neg_q     <= neg_d;
      ovf_q     <= ovf_d;
      bcd_q     <= bcd_d;
      out_neg_q <= out_neg_d;
      out_ovf_q <= out_ovf_d;
    end
  end

  assign bus.in_ready     = (state_q == IDLE);
  assign bus.out_valid    = (state_q == DONE);
  assign bus.out_bcd      = bcd_q;
  assign bus.out_negative = out_neg_q;
  assign bus.out_overflow = out_ovf_q;

endmodule

// File: tb/tb_binary_to_bcd_seq.sv
// Directed bench for binary_to_bcd_seq: a saturating 20-bit/6-digit unit,
// a truncating 20-bit/6-digit unit and a saturating 8-bit/3-digit unit.
module tb_binary_to_bcd_seq;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  binary_to_bcd_seq_if #(.BIN_WIDTH(20), .BCD_DIGITS(6)) ifa ();
  binary_to_bcd_seq_if #(.BIN_WIDTH(20), .BCD_DIGITS(6)) ifb ();
  binary_to_bcd_seq_if #(.BIN_WIDTH(8),  .BCD_DIGITS(3)) ifc ();

  binary_to_bcd_seq #(.BIN_WIDTH(20), .BCD_DIGITS(6), .SATURATE(1'b1)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(ifa));
  binary_to_bcd_seq #(.BIN_WIDTH(20), .BCD_DIGITS(6), .SATURATE(1'b0)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(ifb));
  binary_to_bcd_seq #(.BIN_WIDTH(8), .BCD_DIGITS(3), .SATURATE(1'b1)) dut_c (
    .clk(clk), .reset_n(reset_n), .bus(ifc));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Handshake drivers: they only move data; each test checks the results.
  task automatic run_a(input logic [19:0] bin, input logic sgn, output logic vld,
                       output logic [23:0] bcd, output logic neg, output logic ovf,
                       output int lat);
    int n;
    n = 0;
    ifa.in_binary = bin; ifa.in_signed = sgn; ifa.in_valid = 1'b1; ifa.out_ready = 1'b0;
    while (!ifa.in_ready && n < 100) begin step(); n++; end
    step();
    ifa.in_valid = 1'b0;
    lat = 0;
    while (!ifa.out_valid && lat < 100) begin step(); lat++; end
    vld = ifa.out_valid; bcd = ifa.out_bcd; neg = ifa.out_negative; ovf = ifa.out_overflow;
    $display("[A] in=%h signed=%b -> valid=%b bcd=%h neg=%b ovf=%b lat=%0d",
             bin, sgn, vld, bcd, neg, ovf, lat);
    ifa.out_ready = 1'b1;
    step();
    ifa.out_ready = 1'b0;
  endtask

  task automatic run_b(input logic [19:0] bin, input logic sgn, output logic vld,
                       output logic [23:0] bcd, output logic neg, output logic ovf);
    int n;
    n = 0;
    ifb.in_binary = bin; ifb.in_signed = sgn; ifb.in_valid = 1'b1; ifb.out_ready = 1'b0;
    while (!ifb.in_ready && n < 100) begin step(); n++; end
    step();
    ifb.in_valid = 1'b0;
    n = 0;
    while (!ifb.out_valid && n < 100) begin step(); n++; end
    vld = ifb.out_valid; bcd = ifb.out_bcd; neg = ifb.out_negative; ovf = ifb.out_overflow;
    $display("[B] in=%h signed=%b -> valid=%b bcd=%h neg=%b ovf=%b", bin, sgn, vld, bcd, neg, ovf);
    ifb.out_ready = 1'b1;
    step();
    ifb.out_ready = 1'b0;
  endtask

  task automatic run_c(input logic [7:0] bin, input logic sgn, output logic vld,
                       output logic [11:0] bcd, output logic neg, output logic ovf,
                       output int lat);
    int n;
    n = 0;
    ifc.in_binary = bin; ifc.in_signed = sgn; ifc.in_valid = 1'b1; ifc.out_ready = 1'b0;
    while (!ifc.in_ready && n < 100) begin step(); n++; end
    step();
    ifc.in_valid = 1'b0;
    lat = 0;
    while (!ifc.out_valid && lat < 100) begin step(); lat++; end
    vld = ifc.out_valid; bcd = ifc.out_bcd; neg = ifc.out_negative; ovf = ifc.out_overflow;
    $display("[C] in=%h signed=%b -> valid=%b bcd=%h neg=%b ovf=%b", bin, sgn, vld, bcd, neg, ovf);
    ifc.out_ready = 1'b1;
    step();
    ifc.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step();
    checks++;
    if ({ifa.in_ready, ifa.out_valid, ifa.out_bcd, ifa.out_negative, ifa.out_overflow}
        !== {1'b1, 1'b0, 24'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got rdy=%b vld=%b bcd=%h neg=%b ovf=%b, expected rdy=1 vld=0 bcd=000000 neg=0 ovf=0",
               ifa.in_ready, ifa.out_valid, ifa.out_bcd, ifa.out_negative, ifa.out_overflow);
    end
    reset_n = 1'b1;
    step();
    checks++;
    if ({ifb.in_ready, ifb.out_valid, ifc.in_ready, ifc.out_valid, ifc.out_bcd}
        !== {1'b1, 1'b0, 1'b1, 1'b0, 12'h0}) begin
      errors++;
      $display("FAIL reset_other: got b_rdy=%b b_vld=%b c_rdy=%b c_vld=%b c_bcd=%h, expected 1 0 1 0 000",
               ifb.in_ready, ifb.out_valid, ifc.in_ready, ifc.out_valid, ifc.out_bcd);
    end
  endtask

  task automatic test_basic();
    int lat;
    ifa.in_binary = 20'd12345; ifa.in_signed = 1'b0; ifa.in_valid = 1'b1; ifa.out_ready = 1'b1;
    step();
    ifa.in_valid = 1'b0;
    checks++;
    if (ifa.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_ready_drop: got in_ready=%b, expected 0", ifa.in_ready);
    end
    lat = 0;
    while (!ifa.out_valid && lat < 100) begin step(); lat++; end
    $display("[A] in=12345 signed=0 -> bcd=%h neg=%b ovf=%b lat=%0d",
             ifa.out_bcd, ifa.out_negative, ifa.out_overflow, lat);
    checks++;
    if (lat !== 20) begin
      errors++;
      $display("FAIL basic_latency: got %0d edges, expected 20", lat);
    end
    checks++;
    if ({ifa.out_bcd, ifa.out_negative, ifa.out_overflow} !== {24'h012345, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL basic_value: got bcd=%h neg=%b ovf=%b, expected bcd=012345 neg=0 ovf=0",
               ifa.out_bcd, ifa.out_negative, ifa.out_overflow);
    end
    step();
    ifa.out_ready = 1'b0;
    checks++;
    if ({ifa.out_valid, ifa.in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL basic_release: got vld=%b rdy=%b, expected vld=0 rdy=1", ifa.out_valid, ifa.in_ready);
    end
  endtask

  task automatic test_signed();
    logic [19:0] vin  [3] = '{20'h80000, 20'hFFFFF, 20'h7FFFF};
    logic [23:0] vbcd [3] = '{24'h524288, 24'h000001, 24'h524287};
    logic        vneg [3] = '{1'b1, 1'b1, 1'b0};
    logic vld, neg, ovf;
    logic [23:0] bcd;
    int lat;
    for (int i = 0; i < 3; i++) begin
      run_a(vin[i], 1'b1, vld, bcd, neg, ovf, lat);
      checks++;
      if ({vld, bcd, neg, ovf} !== {1'b1, vbcd[i], vneg[i], 1'b0}) begin
        errors++;
        $display("FAIL signed_%0d: got vld=%b bcd=%h neg=%b ovf=%b, expected vld=1 bcd=%h neg=%b ovf=0",
                 i, vld, bcd, neg, ovf, vbcd[i], vneg[i]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [19:0] vin   [3] = '{20'hFFFFF, 20'd1000000, 20'd999999};
    logic [23:0] vsat  [3] = '{24'h999999, 24'h999999, 24'h999999};
    logic [23:0] vtrn  [3] = '{24'h048575, 24'h000000, 24'h999999};
    logic        vovf  [3] = '{1'b1, 1'b1, 1'b0};
    logic vld, neg, ovf;
    logic [23:0] bcd;
    int lat;
    for (int i = 0; i < 3; i++) begin
      run_a(vin[i], 1'b0, vld, bcd, neg, ovf, lat);
      checks++;
      if ({vld, bcd, neg, ovf} !== {1'b1, vsat[i], 1'b0, vovf[i]}) begin
        errors++;
        $display("FAIL ovf_sat_%0d: got vld=%b bcd=%h neg=%b ovf=%b, expected vld=1 bcd=%h neg=0 ovf=%b",
                 i, vld, bcd, neg, ovf, vsat[i], vovf[i]);
      end
      run_b(vin[i], 1'b0, vld, bcd, neg, ovf);
      checks++;
      if ({vld, bcd, neg, ovf} !== {1'b1, vtrn[i], 1'b0, vovf[i]}) begin
        errors++;
        $display("FAIL ovf_trunc_%0d: got vld=%b bcd=%h neg=%b ovf=%b, expected vld=1 bcd=%h neg=0 ovf=%b",
                 i, vld, bcd, neg, ovf, vtrn[i], vovf[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    int bad;
    ifa.in_binary = 20'd42; ifa.in_signed = 1'b0; ifa.in_valid = 1'b1; ifa.out_ready = 1'b0;
    step();
    ifa.in_valid = 1'b0;
    lat = 0;
    while (!ifa.out_valid && lat < 100) begin step(); lat++; end
    checks++;
    if ({ifa.out_valid, ifa.out_bcd} !== {1'b1, 24'h000042}) begin
      errors++;
      $display("FAIL bp_first: got vld=%b bcd=%h, expected vld=1 bcd=000042", ifa.out_valid, ifa.out_bcd);
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      ifa.in_valid  = i[0];
      ifa.in_binary = 20'($urandom);
      ifa.in_signed = i[1];
      step();
      $display("[A] stall %0d: vld=%b rdy=%b bcd=%h", i, ifa.out_valid, ifa.in_ready, ifa.out_bcd);
      if ({ifa.out_valid, ifa.in_ready, ifa.out_bcd} !== {1'b1, 1'b0, 24'h000042}) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL bp_hold: got %0d stall cycles with changed outputs, expected 0", bad);
    end
    ifa.out_ready = 1'b1; ifa.in_valid = 1'b1; ifa.in_binary = 20'd999999; ifa.in_signed = 1'b0;
    step();
    ifa.out_ready = 1'b0;
    checks++;
    if ({ifa.out_valid, ifa.in_ready, ifa.out_bcd} !== {1'b0, 1'b1, 24'h000042}) begin
      errors++;
      $display("FAIL bp_release: got vld=%b rdy=%b bcd=%h, expected vld=0 rdy=1 bcd=000042",
               ifa.out_valid, ifa.in_ready, ifa.out_bcd);
    end
    step();
    ifa.in_valid = 1'b0;
    lat = 0;
    while (!ifa.out_valid && lat < 100) begin step(); lat++; end
    $display("[A] in=999999 signed=0 -> bcd=%h ovf=%b lat=%0d", ifa.out_bcd, ifa.out_overflow, lat);
    checks++;
    if ({lat == 20, ifa.out_bcd, ifa.out_negative, ifa.out_overflow} !== {1'b1, 24'h999999, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL bp_second: got lat=%0d bcd=%h neg=%b ovf=%b, expected lat=20 bcd=999999 neg=0 ovf=0",
               lat, ifa.out_bcd, ifa.out_negative, ifa.out_overflow);
    end
    ifa.out_ready = 1'b1;
    step();
    ifa.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int seen;
    logic vld, neg, ovf;
    logic [23:0] bcd;
    int lat;
    ifa.in_binary = 20'd54321; ifa.in_signed = 1'b0; ifa.in_valid = 1'b1; ifa.out_ready = 1'b1;
    step();
    ifa.in_valid = 1'b0;
    repeat (10) step();
    reset_n = 1'b0;
    step();
    checks++;
    if ({ifa.in_ready, ifa.out_valid, ifa.out_bcd} !== {1'b1, 1'b0, 24'h0}) begin
      errors++;
      $display("FAIL midreset_state: got rdy=%b vld=%b bcd=%h, expected rdy=1 vld=0 bcd=000000",
               ifa.in_ready, ifa.out_valid, ifa.out_bcd);
    end
    reset_n = 1'b1;
    seen = 0;
    repeat (30) begin
      step();
      if (ifa.out_valid !== 1'b0) seen++;
    end
    ifa.out_ready = 1'b0;
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL midreset_stale: got out_valid high in %0d cycles, expected 0", seen);
    end
    run_a(20'd7, 1'b0, vld, bcd, neg, ovf, lat);
    checks++;
    if ({vld, bcd, neg, ovf} !== {1'b1, 24'h000007, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL midreset_after: got vld=%b bcd=%h neg=%b ovf=%b, expected vld=1 bcd=000007 neg=0 ovf=0",
               vld, bcd, neg, ovf);
    end
  endtask

  task automatic test_zero();
    logic vld, neg, ovf;
    logic [23:0] bcd;
    int lat;
    for (int s = 0; s < 2; s++) begin
      run_a(20'd0, s[0], vld, bcd, neg, ovf, lat);
      checks++;
      if ({vld, bcd, neg, ovf} !== {1'b1, 24'h0, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL zero_s%0d: got vld=%b bcd=%h neg=%b ovf=%b, expected vld=1 bcd=000000 neg=0 ovf=0",
                 s, vld, bcd, neg, ovf);
      end
    end
  endtask

  task automatic test_sweep();
    logic vld, neg, ovf;
    logic [11:0] bcd;
    logic [11:0] exp_bcd;
    logic exp_neg;
    logic [7:0] b;
    int lat, v;
    run_c(8'hFF, 1'b0, vld, bcd, neg, ovf, lat);
    checks++;
    if ({vld, bcd, neg, ovf, lat == 8} !== {1'b1, 12'h255, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL sweep_ff_u: got vld=%b bcd=%h neg=%b ovf=%b lat=%0d, expected vld=1 bcd=255 neg=0 ovf=0 lat=8",
               vld, bcd, neg, ovf, lat);
    end
    run_c(8'hFF, 1'b1, vld, bcd, neg, ovf, lat);
    checks++;
    if ({vld, bcd, neg, ovf} !== {1'b1, 12'h001, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL sweep_ff_s: got vld=%b bcd=%h neg=%b ovf=%b, expected vld=1 bcd=001 neg=1 ovf=0",
               vld, bcd, neg, ovf);
    end
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 256; i++) begin
        b = 8'(i);
        exp_neg = s[0] && b[7];
        v = exp_neg ? 256 - i : i;
        exp_bcd = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
        run_c(b, s[0], vld, bcd, neg, ovf, lat);
        checks++;
        if ({vld, bcd, neg, ovf} !== {1'b1, exp_bcd, exp_neg, 1'b0}) begin
          errors++;
          $display("FAIL sweep_%0d_%0d: got vld=%b bcd=%h neg=%b ovf=%b, expected vld=1 bcd=%h neg=%b ovf=0",
                   s, i, vld, bcd, neg, ovf, exp_bcd, exp_neg);
        end
      end
    end
  endtask

  initial begin
    ifa.in_valid = 1'b0; ifa.in_binary = '0; ifa.in_signed = 1'b0; ifa.out_ready = 1'b0;
    ifb.in_valid = 1'b0; ifb.in_binary = '0; ifb.in_signed = 1'b0; ifb.out_ready = 1'b0;
    ifc.in_valid = 1'b0; ifc.in_binary = '0; ifc.in_signed = 1'b0; ifc.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_signed();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_zero();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
